pwm_carrier_counter: RTL

// Carrier counter for one PWM channel; consumes the packed PWM config word and period/divider values written over AXI4-Lite.

---
 rtl/pwm_carrier_counter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/pwm_carrier_counter.sv
// pwm_carrier_counter
//   Carrier counter for one PWM channel. New config, period and divider
//   values are written into a shadow copy. They become active only at a
//   carrier boundary, or at any time while the channel is off, so a
//   running carrier period is never split.
//
// Ports
//   clk            system clock
//   resetn         asynchronous active-low reset
//   cfg_word       [6]pwm_onoff [5]int_onoff [4]pwmclkdiv_onoff
//                  [3]dtclkdiv_onoff [2]mask_mode [1:0]count_mode
//   cfg_period     carrier period (top count)
//   cfg_clkdiv     prescaler: a tick occurs every cfg_clkdiv+1 clocks
//                  when the divider is enabled
//   cfg_valid      1-cycle strobe that captures the cfg_* inputs
//   count          carrier count
//   count_dir      1 = counting up, 0 = counting down
//   evt_zero       1-cycle pulse: count entered 0 on a tick
//   evt_period     1-cycle pulse: count entered the active period on a tick
//   irq            evt_zero qualified by the active int_onoff
//   update_pending shadow holds values that are not yet active
//   cfg_active     active config word
module pwm_carrier_counter #(
   parameter int CNT_WIDTH = 16,
   parameter int DIV_WIDTH = 8,
   parameter int CFG_WIDTH = 7
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [CFG_WIDTH-1:0] cfg_word,
   input  logic [CNT_WIDTH-1:0] cfg_period,
   input  logic [DIV_WIDTH-1:0] cfg_clkdiv,
   input  logic                 cfg_valid,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 count_dir,
   output logic                 evt_zero,
   output logic                 evt_period,
   output logic                 irq,
   output logic                 update_pending,
   output logic [CFG_WIDTH-1:0] cfg_active
);

   localparam int B_PWM_ON = 6;
   localparam int B_INT_ON = 5;
   localparam int B_DIV_ON = 4;

   localparam logic [1:0] M_UP     = 2'b00;
   localparam logic [1:0] M_DOWN   = 2'b01;
   localparam logic [1:0] M_UPDOWN = 2'b10;

   localparam logic [CNT_WIDTH-1:0] C_ZERO = '0;
   localparam logic [CNT_WIDTH-1:0] C_ONE  = CNT_WIDTH'(1);

   // shadow (written) and active (committed) copies
   logic [CFG_WIDTH-1:0] r_sh_cfg, r_cfg;
   logic [CNT_WIDTH-1:0] r_sh_period, r_period;
   logic [DIV_WIDTH-1:0] r_sh_div, r_div;
   logic                 r_pending;

   logic [DIV_WIDTH-1:0] r_presc;
   logic [CNT_WIDTH-1:0] r_count;
   logic                 r_dir;
   logic                 r_evt_zero, r_evt_period, r_irq;

   logic [1:0]           w_mode;
   logic                 w_on, w_tick, w_boundary, w_commit;
   logic [CFG_WIDTH-1:0] w_new_cfg, w_cfg_eff;
   logic [CNT_WIDTH-1:0] w_new_period, w_per_eff;
   logic [DIV_WIDTH-1:0] w_new_div;
   logic [CNT_WIDTH-1:0] w_next_count;
   logic                 w_next_dir;

   assign w_mode = r_cfg[1:0];
   assign w_on   = r_cfg[B_PWM_ON];
   assign w_tick = w_on && (!r_cfg[B_DIV_ON] || (r_presc == r_div));

   // A strobe in the commit cycle bypasses the shadow and goes straight
   // to the active registers.
   assign w_new_cfg    = cfg_valid ? cfg_word   : r_sh_cfg;
   assign w_new_period = cfg_valid ? cfg_period : r_sh_period;
   assign w_new_div    = cfg_valid ? cfg_clkdiv : r_sh_div;

   // Boundary is evaluated from the current count only. This keeps it
   // independent of the commit decision that it drives.
   always_comb begin
      w_boundary = 1'b0;
      case (w_mode)
         M_UP:     w_boundary = (r_count >= r_period);
         M_DOWN:   w_boundary = (r_count == C_ZERO);
         M_UPDOWN: w_boundary = (r_period == C_ZERO) || (!r_dir && (r_count <= C_ONE));
         default:  w_boundary = 1'b0;
      endcase
   end

   assign w_commit  = ((w_tick && w_boundary) || !w_on) && (r_pending || cfg_valid);
   assign w_cfg_eff = w_commit ? w_new_cfg    : r_cfg;
   assign w_per_eff = w_commit ? w_new_period : r_period;

   always_comb begin
      w_next_count = r_count;
      w_next_dir   = r_dir;
      case (w_mode)
         M_UP: begin
            w_next_dir   = 1'b1;
            w_next_count = (r_count >= r_period) ? C_ZERO : r_count + C_ONE;
         end
         M_DOWN: begin
            // the reload takes a period committed at this boundary
            w_next_dir   = 1'b0;
            w_next_count = (r_count == C_ZERO) ? w_per_eff : r_count - C_ONE;
         end
         M_UPDOWN: begin
            if (r_period == C_ZERO) begin
               w_next_count = C_ZERO;
               w_next_dir   = 1'b1;
            end else if (r_dir) begin
               // direction flips as the count arrives at the peak
               if (r_count >= r_period - C_ONE) begin
                  w_next_count = r_period;
                  w_next_dir   = 1'b0;
               end else begin
                  w_next_count = r_count + C_ONE;
               end
            end else begin
               if (r_count <= C_ONE) begin
                  w_next_count = C_ZERO;
                  w_next_dir   = 1'b1;
               end else begin
                  w_next_count = r_count - C_ONE;
               end
            end
         end
         default: begin
            w_next_count = r_count;
            w_next_dir   = r_dir;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_sh_cfg     <= '0;
         r_sh_period  <= '0;
         r_sh_div     <= '0;
         r_cfg        <= '0;
         r_period     <= '0;
         r_div        <= '0;
         r_pending    <= 1'b0;
         r_presc      <= '0;
         r_count      <= '0;
         r_dir        <= 1'b1;
         r_evt_zero   <= 1'b0;
         r_evt_period <= 1'b0;
         r_irq        <= 1'b0;
      end else begin
         if (cfg_valid) begin
            r_sh_cfg    <= cfg_word;
            r_sh_period <= cfg_period;
            r_sh_div    <= cfg_clkdiv;
         end
         if (w_commit) begin
            r_cfg    <= w_new_cfg;
            r_period <= w_new_period;
            r_div    <= w_new_div;
         end
         r_pending <= (r_pending || cfg_valid) && !w_commit;

         r_evt_zero   <= 1'b0;
         r_evt_period <= 1'b0;
         r_irq        <= 1'b0;

         if (!w_on) begin
            // While the channel is off, the count is parked at the start
            // value of the config that is active next cycle.
            r_presc <= '0;
            if (w_cfg_eff[1:0] == M_DOWN) begin
               r_count <= w_per_eff;
               r_dir   <= 1'b0;
            end else begin
               r_count <= C_ZERO;
               r_dir   <= 1'b1;
            end
         end else begin
            if (w_commit || !r_cfg[B_DIV_ON] || (r_presc == r_div))
               r_presc <= '0;
            else
               r_presc <= r_presc + 1'b1;

            if (w_tick && (w_mode != 2'b11)) begin
               r_count      <= w_next_count;
               r_dir        <= w_next_dir;
               r_evt_zero   <= (w_next_count == C_ZERO);
               r_evt_period <= (w_next_count == w_per_eff);
               r_irq        <= (w_next_count == C_ZERO) && r_cfg[B_INT_ON];
            end
         end
      end
   end

   assign count          = r_count;
   assign count_dir      = r_dir;
   assign evt_zero       = r_evt_zero;
   assign evt_period     = r_evt_period;
   assign irq            = r_irq;
   assign update_pending = r_pending;
   assign cfg_active     = r_cfg;

endmodule
